intr_arbiter: RTL and testbench

- Sequences and shares a single CPU interrupt line among NumSrc peripheral interrupt outputs.
- Each source is the flopped `intr_o` of a per-peripheral interrupt primitive (level, held until software clears INTR_STATE).
- Provides per-source gateways, pending latches, round-robin selection, and a claim/complete handshake so exactly one source is in service at a time.
- Sits between peripheral interrupt outputs and the core's external-interrupt input.

---
 rtl/intr_arbiter.sv | 156 +++++++++++++++
 tb/tb_intr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_arbiter.sv
// Shares one CPU interrupt line among NumSrc level sources. Each source has a gateway
// and a pending latch. Offers are round-robin, and only one source is claimed at a time.
module intr_arbiter #(
  parameter int NumSrc = 8,
  parameter int IdW    = $clog2(NumSrc + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] intr_src_i,
  input  logic [NumSrc-1:0] src_enable_i,
  output logic              irq_o,
  output logic [IdW-1:0]    irq_id_o,
  input  logic              claim_i,
  output logic [IdW-1:0]    claimed_id_o,
  input  logic              complete_i,
  input  logic [IdW-1:0]    complete_id_i,
  output logic [NumSrc-1:0] pending_o,
  output logic              err_o
);

  // Handshake: irq_o/irq_id_o hold an offer steady until a claim_i pulse accepts it.
  // The accepted ID stays on claimed_id_o until a complete_i pulse with a matching
  // complete_id_i ends the service. Any other pulse is dropped and flagged on err_o.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NOTIFY  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NumSrc-1:0]   pending_q, pending_d;
  logic [NumSrc-1:0]   gate_open_q, gate_open_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]      irq_id_q, irq_id_d;
  logic [IdW-1:0]      claimed_id_q, claimed_id_d;
  logic                irq_q, irq_d;
  logic                err_q, err_d;

  logic [NumSrc-1:0]   eligible;
  logic [NumSrc-1:0]   new_req;
  logic [2*NumSrc-1:0] elig_dbl;
  logic [NumSrc-1:0]   elig_rot;
  logic                any_eligible;
  logic [IdW-1:0]      winner_id;
  int                  pos;

  function automatic logic [NumSrc-1:0] id_mask(input logic [IdW-1:0] id);
    logic [NumSrc-1:0] m;
    m = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (int'(id) == i + 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign eligible = pending_q & src_enable_i;
  assign new_req  = gate_open_q & src_enable_i & intr_src_i;

  // Rotate so that bit 0 is rr_ptr. The first set bit is then the round-robin winner.
  always_comb begin
    elig_dbl     = {eligible, eligible} >> rr_ptr_q;
    elig_rot     = elig_dbl[NumSrc-1:0];
    any_eligible = 1'b0;
    winner_id    = '0;
    pos          = 0;
    for (int k = 0; k < NumSrc; k++) begin
      if (!any_eligible && elig_rot[k]) begin
        any_eligible = 1'b1;
        pos          = int'(rr_ptr_q) + k;
        if (pos >= NumSrc) pos = pos - NumSrc;
        winner_id    = IdW'(pos + 1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | new_req;
    gate_open_d  = gate_open_q & ~new_req;
    rr_ptr_d     = rr_ptr_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    claimed_id_d = claimed_id_q;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (claim_i || complete_i) err_d = 1'b1;
        if (any_eligible) begin
          irq_d    = 1'b1;
          irq_id_d = winner_id;
          state_d  = NOTIFY;
        end
      end
      NOTIFY: begin
        if (complete_i) err_d = 1'b1;
        if (claim_i) begin
          pending_d    = pending_d & ~id_mask(irq_id_q);
          claimed_id_d = irq_id_q;
          rr_ptr_d     = (int'(irq_id_q) >= NumSrc) ? '0 : irq_id_q;
          irq_d        = 1'b0;
          irq_id_d     = '0;
          state_d      = SERVICE;
        end else if ((id_mask(irq_id_q) & src_enable_i) == '0) begin
          // The offered source was disabled, so withdraw the offer and arbitrate again.
          irq_d    = 1'b0;
          irq_id_d = '0;
          state_d  = IDLE;
        end
      end
      SERVICE: begin
        if (claim_i) err_d = 1'b1;
        if (complete_i) begin
          if (complete_id_i == claimed_id_q) begin
            gate_open_d  = gate_open_d | id_mask(claimed_id_q);
            claimed_id_d = '0;
            state_d      = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      gate_open_q  <= '1;
      rr_ptr_q     <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      claimed_id_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      gate_open_q  <= gate_open_d;
      rr_ptr_q     <= rr_ptr_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      claimed_id_q <= claimed_id_d;
      err_q        <= err_d;
    end
  end

  assign irq_o        = irq_q;
  assign irq_id_o     = irq_id_q;
  assign claimed_id_o = claimed_id_q;
  assign pending_o    = pending_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: a reference model predicts every cycle's outputs into a queue,
// and a monitor pops the queue and compares it with the DUT.
module tb_intr_arbiter;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam int W  = 1 + IW + IW + N + 1;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [N-1:0]  src = '0;
  logic [N-1:0]  en = '1;
  logic          claim = 1'b0;
  logic          complete = 1'b0;
  logic [IW-1:0] cid = '0;
  logic          irq_o;
  logic [IW-1:0] irq_id_o;
  logic [IW-1:0] claimed_id_o;
  logic [N-1:0]  pending_o;
  logic          err_o;

  intr_arbiter #(.NumSrc(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .intr_src_i   (src),
    .src_enable_i (en),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .claim_i      (claim),
    .claimed_id_o (claimed_id_o),
    .complete_i   (complete),
    .complete_id_i(cid),
    .pending_o    (pending_o),
    .err_o        (err_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sets of pending and open gateways, plus the current phase of the handshake
  bit m_pend[N];
  bit m_open[N];
  int m_rr = 0;
  int m_phase = 0;
  int m_id = 0;
  int m_claimed = 0;
  bit m_irq = 0;
  bit m_err = 0;

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (m_pend[i] && en[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit old_open[N];
    bit new_req[N];
    int w;
    int reopen;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_open[i] = 1;
      end
      m_rr = 0; m_phase = 0; m_id = 0; m_claimed = 0; m_irq = 0; m_err = 0;
      return;
    end
    old_open = m_open;
    reopen = -1;
    m_err = 0;
    for (int i = 0; i < N; i++) new_req[i] = old_open[i] && en[i] && src[i];
    case (m_phase)
      0: begin
        if (claim || complete) m_err = 1;
        w = pick();
        if (w >= 0) begin
          m_id = w + 1; m_irq = 1; m_phase = 1;
        end
      end
      1: begin
        if (complete) m_err = 1;
        if (claim) begin
          m_pend[m_id-1] = 0;
          m_claimed = m_id;
          m_rr = m_id % N;
          m_id = 0; m_irq = 0; m_phase = 2;
        end else if (!en[m_id-1]) begin
          m_id = 0; m_irq = 0; m_phase = 0;
        end
      end
      default: begin
        if (claim) m_err = 1;
        if (complete) begin
          if (int'(cid) == m_claimed) begin
            reopen = m_claimed - 1; m_claimed = 0; m_phase = 0;
          end else begin
            m_err = 1;
          end
        end
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (new_req[i]) begin
        m_pend[i] = 1; m_open[i] = 0;
      end
    end
    if (reopen >= 0) m_open[reopen] = 1;
  endtask

  // Driver: inputs change 2 time units after each edge, and the prediction for the next edge is queued
  task automatic tick();
    logic [N-1:0] pv;
    model_step();
    for (int i = 0; i < N; i++) pv[i] = m_pend[i];
    exp_q.push_back({m_irq, IW'(m_id), IW'(m_claimed), pv, m_err});
    @(posedge clk);
    #2;
    claim = 1'b0;
    complete = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(input string name);
    int n;
    n = 0;
    while (!m_irq && n < 20) begin
      tick();
      n++;
    end
    check(name, irq_o, 1);
  endtask

  task automatic serve(input int id_now);
    claim = 1'b1;
    tick();
    complete = 1'b1;
    cid = IW'(id_now);
    tick();
  endtask

  // Monitor: compares one queued prediction against the DUT one time unit after each edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_irq", irq_o, e[W-1]);
        check("sb_irq_id", irq_id_o, e[W-2 -: IW]);
        check("sb_claimed", claimed_id_o, e[W-2-IW -: IW]);
        check("sb_pending", pending_o, e[N:1]);
        check("sb_err", err_o, e[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int rr_ids[6];
    rr_ids = '{1, 4, 8, 1, 4, 8};
    #0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("reset_outputs", {irq_o, irq_id_o, claimed_id_o, pending_o, err_o}, 0);

    // Single source: offer latency, claim, complete, then a re-pend
    en = '1; src = 8'h04;
    tick(); tick();
    check("single_offer", {irq_o, irq_id_o}, {1'b1, 4'd3});
    claim = 1'b1; tick();
    check("single_claim", {irq_o, claimed_id_o}, {1'b0, 4'd3});
    tick();
    complete = 1'b1; cid = 4'd3; tick();
    check("single_complete", claimed_id_o, 0);
    tick(); tick();
    check("single_repend", {irq_o, irq_id_o}, {1'b1, 4'd3});
    src = '0;
    serve(3);

    // Round-robin fairness
    do_reset();
    src = 8'h89;
    for (int k = 0; k < 6; k++) begin
      wait_offer("rr_wait");
      check("rr_order", irq_id_o, rr_ids[k]);
      claim = 1'b1; tick(); tick();
      complete = 1'b1; cid = IW'(m_claimed); tick();
    end
    src = '0;

    // Disable while offered
    do_reset();
    src = 8'h20;
    wait_offer("dis_wait");
    check("dis_offer", irq_id_o, 6);
    en = 8'hDF; tick();
    check("dis_drop_irq", irq_o, 0);
    check("dis_keep_pend", pending_o[5], 1);
    en = 8'hFF; tick();
    check("dis_reoffer", {irq_o, irq_id_o}, {1'b1, 4'd6});
    src = '0;
    serve(6);

    // Protocol errors
    claim = 1'b1; tick();
    check("err_claim_idle", err_o, 1);
    check("err_claim_idle_irq", {irq_o, claimed_id_o}, 0);
    tick();
    check("err_pulse_end", err_o, 0);
    src = 8'h10;
    wait_offer("err_wait");
    claim = 1'b1; tick();
    check("err_svc_id", claimed_id_o, 5);
    complete = 1'b1; cid = 4'd2; tick();
    check("err_bad_id", err_o, 1);
    check("err_keep_svc", claimed_id_o, 5);
    tick();
    check("err_bad_id_end", err_o, 0);
    src = '0;
    complete = 1'b1; cid = 4'd5; tick();
    check("err_good_complete", {claimed_id_o, err_o}, 0);

    // Reset mid-service
    src = 8'h08;
    wait_offer("rst_wait");
    claim = 1'b1; tick();
    check("rst_svc_id", claimed_id_o, 4);
    do_reset();
    check("rst_outputs", {irq_o, irq_id_o, claimed_id_o, pending_o, err_o}, 0);
    tick(); tick();
    check("rst_reoffer", {irq_o, irq_id_o}, {1'b1, 4'd4});
    src = '0;
    serve(4);

    // Wrap-around: the claim of id 6 leaves rr_ptr at 6, and the claim of id 7 leaves it at 7
    do_reset();
    src = 8'h20;
    wait_offer("wrap_wait0");
    claim = 1'b1; tick();
    src = 8'h62; tick();
    src = 8'h42;
    complete = 1'b1; cid = 4'd6; tick();
    wait_offer("wrap_wait1");
    check("wrap_first", irq_id_o, 7);
    claim = 1'b1; tick();
    src = 8'h02;
    complete = 1'b1; cid = 4'd7; tick();
    wait_offer("wrap_wait2");
    check("wrap_second", irq_id_o, 2);
    src = '0;
    serve(2);

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      if (($urandom % 8) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 49) == 0) en = N'($urandom);
      if (m_irq && $urandom_range(0, 3) == 0) claim = 1'b1;
      else if ($urandom_range(0, 39) == 0) claim = 1'b1;
      if (m_phase == 2 && $urandom_range(0, 4) == 0) begin
        complete = 1'b1;
        cid = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(0, N)) : IW'(m_claimed);
      end else if ($urandom_range(0, 59) == 0) begin
        complete = 1'b1;
        cid = IW'($urandom_range(0, N));
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
